altera_tse_xcvr_reset_responder: RTL

Synthesizable transceiver-side model of the Stratix IV reset/status interface. It consumes the reset and powerdown controls that a reset sequencer drives, and produces the PLL lock, offset-cancellation busy and CDR lock-to-data status that the sequencer waits on. It also flags reset-ordering violations with sticky error bits. It is used in simulation benches and in FPGA bring-up builds that have no hard transceiver.

---
 rtl/altera_tse_xcvr_reset_responder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/altera_tse_xcvr_reset_responder.sv
// Transceiver-side stand-in for the Stratix IV reset/status handshake: models PLL lock,
// offset-cancellation busy and CDR lock-to-data timing, and flags reset-ordering mistakes.
`timescale 1ns/1ps

module altera_tse_xcvr_reset_responder #(
   parameter int unsigned pll_lock_cycles = 20,
   parameter int unsigned oc_busy_cycles  = 16,
   parameter int unsigned ltd_cycles      = 12
) (
   input  logic clock,
   input  logic reset,
   input  logic pll_powerdown,
   input  logic tx_digitalreset,
   input  logic rx_analogreset,
   input  logic rx_digitalreset,
   input  logic gxb_powerdown,
   input  logic rx_signal_present,
   input  logic err_clear,
   output logic pll_is_locked,
   output logic rx_oc_busy,
   output logic rx_is_lockedtodata,
   output logic err_tx_early,
   output logic err_rx_order,
   output logic err_rx_early
);

   localparam int unsigned PLL_CW = $clog2(pll_lock_cycles + 1);
   localparam int unsigned OC_CW  = $clog2(oc_busy_cycles + 1);
   localparam int unsigned LTD_CW = $clog2(ltd_cycles + 1);

   localparam logic [PLL_CW-1:0] PLL_LAST = PLL_CW'(pll_lock_cycles);
   localparam logic [OC_CW-1:0]  OC_LAST  = OC_CW'(oc_busy_cycles);
   localparam logic [LTD_CW-1:0] LTD_LAST = LTD_CW'(ltd_cycles);

   typedef enum logic [1:0] {PLL_OFF, PLL_LOCKING, PLL_LOCKED} pll_state_t;
   typedef enum logic [1:0] {OC_IDLE, OC_BUSY, OC_DONE}        oc_state_t;
   typedef enum logic [1:0] {CDR_RESET, CDR_LTR, CDR_LTD}      cdr_state_t;

   pll_state_t        pll_state, pll_state_nxt;
   logic [PLL_CW-1:0] pll_cnt, pll_cnt_nxt;
   logic              pll_lock_nxt;

   oc_state_t         oc_state, oc_state_nxt;
   logic [OC_CW-1:0]  oc_cnt, oc_cnt_nxt;
   logic              oc_busy_nxt;

   cdr_state_t        cdr_state, cdr_state_nxt;
   logic [LTD_CW-1:0] cdr_cnt, cdr_cnt_nxt;
   logic              ltd_nxt;
   logic              cdr_hold;

   logic              tx_prev, rx_prev;
   logic              tx_release, rx_release, chk_en;
   logic              err_tx_early_nxt, err_rx_order_nxt, err_rx_early_nxt;

   // TX PLL: lock timer restarts whenever either powerdown is seen
   always_comb begin
      pll_state_nxt = pll_state;
      pll_cnt_nxt   = pll_cnt;
      pll_lock_nxt  = pll_is_locked;
      if (pll_powerdown | gxb_powerdown) begin
         pll_state_nxt = PLL_OFF;
         pll_cnt_nxt   = '0;
         pll_lock_nxt  = 1'b0;
      end else begin
         case (pll_state)
            PLL_OFF: begin
               pll_state_nxt = PLL_LOCKING;
               pll_cnt_nxt   = '0;
               pll_lock_nxt  = 1'b0;
            end
            PLL_LOCKING: begin
               if (pll_cnt == PLL_LAST) begin
                  pll_state_nxt = PLL_LOCKED;
                  pll_lock_nxt  = 1'b1;
               end else begin
                  pll_cnt_nxt   = pll_cnt + PLL_CW'(1);
               end
            end
            PLL_LOCKED: pll_lock_nxt = 1'b1;
            default: begin
               pll_state_nxt = PLL_OFF;
               pll_cnt_nxt   = '0;
               pll_lock_nxt  = 1'b0;
            end
         endcase
      end
   end

   // Offset cancellation runs once per quad power-up
   always_comb begin
      oc_state_nxt = oc_state;
      oc_cnt_nxt   = oc_cnt;
      oc_busy_nxt  = rx_oc_busy;
      if (gxb_powerdown) begin
         oc_state_nxt = OC_IDLE;
         oc_cnt_nxt   = '0;
         oc_busy_nxt  = 1'b0;
      end else begin
         case (oc_state)
            OC_IDLE: begin
               oc_state_nxt = OC_BUSY;
               oc_cnt_nxt   = '0;
               oc_busy_nxt  = 1'b0;
            end
            OC_BUSY: begin
               if (oc_cnt == OC_LAST) begin
                  oc_state_nxt = OC_DONE;
                  oc_busy_nxt  = 1'b0;
               end else begin
                  oc_cnt_nxt   = oc_cnt + OC_CW'(1);
                  oc_busy_nxt  = 1'b1;
               end
            end
            OC_DONE: oc_busy_nxt = 1'b0;
            default: begin
               oc_state_nxt = OC_IDLE;
               oc_cnt_nxt   = '0;
               oc_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   // CDR: lock-to-reference until the timer expires, held in reset by any upstream condition
   always_comb begin
      cdr_hold      = rx_analogreset | gxb_powerdown | ~pll_is_locked
                    | ~rx_signal_present | rx_oc_busy;
      cdr_state_nxt = cdr_state;
      cdr_cnt_nxt   = cdr_cnt;
      ltd_nxt       = rx_is_lockedtodata;
      if (cdr_hold) begin
         cdr_state_nxt = CDR_RESET;
         cdr_cnt_nxt   = '0;
         ltd_nxt       = 1'b0;
      end else begin
         case (cdr_state)
            CDR_RESET: begin
               cdr_state_nxt = CDR_LTR;
               cdr_cnt_nxt   = '0;
               ltd_nxt       = 1'b0;
            end
            CDR_LTR: begin
               if (cdr_cnt == LTD_LAST) begin
                  cdr_state_nxt = CDR_LTD;
                  ltd_nxt       = 1'b1;
               end else begin
                  cdr_cnt_nxt   = cdr_cnt + LTD_CW'(1);
               end
            end
            CDR_LTD: ltd_nxt = 1'b1;
            default: begin
               cdr_state_nxt = CDR_RESET;
               cdr_cnt_nxt   = '0;
               ltd_nxt       = 1'b0;
            end
         endcase
      end
   end

   // Sticky ordering checks; a new violation beats a simultaneous clear
   always_comb begin
      chk_en           = ~gxb_powerdown;
      tx_release       = tx_prev & ~tx_digitalreset;
      rx_release       = rx_prev & ~rx_digitalreset;
      err_tx_early_nxt = (chk_en & tx_release & ~pll_is_locked)
                       | (err_tx_early & ~err_clear);
      err_rx_order_nxt = (chk_en & ~rx_digitalreset & rx_analogreset)
                       | (err_rx_order & ~err_clear);
      err_rx_early_nxt = (chk_en & rx_release & ~rx_is_lockedtodata)
                       | (err_rx_early & ~err_clear);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pll_state          <= PLL_OFF;
         pll_cnt            <= '0;
         pll_is_locked      <= 1'b0;
         oc_state           <= OC_IDLE;
         oc_cnt             <= '0;
         rx_oc_busy         <= 1'b0;
         cdr_state          <= CDR_RESET;
         cdr_cnt            <= '0;
         rx_is_lockedtodata <= 1'b0;
         tx_prev            <= 1'b0;
         rx_prev            <= 1'b0;
         err_tx_early       <= 1'b0;
         err_rx_order       <= 1'b0;
         err_rx_early       <= 1'b0;
      end else begin
         pll_state          <= pll_state_nxt;
         pll_cnt            <= pll_cnt_nxt;
         pll_is_locked      <= pll_lock_nxt;
         oc_state           <= oc_state_nxt;
         oc_cnt             <= oc_cnt_nxt;
         rx_oc_busy         <= oc_busy_nxt;
         cdr_state          <= cdr_state_nxt;
         cdr_cnt            <= cdr_cnt_nxt;
         rx_is_lockedtodata <= ltd_nxt;
         tx_prev            <= tx_digitalreset;
         rx_prev            <= rx_digitalreset;
         err_tx_early       <= err_tx_early_nxt;
         err_rx_order       <= err_rx_order_nxt;
         err_rx_early       <= err_rx_early_nxt;
      end
   end

endmodule
